// File: rtl/updown_count_sequencer_if.sv
// Control/status bundle for the up/down count sequencer.
// The master drives start/stop/hold and the sweep configuration; the slave (the sequencer)
// returns the count value, its complement, the direction flag and the status pulses.
interface updown_count_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int SWP_W = 4
);
    logic             start;
    logic             stop;
    logic             hold;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [SWP_W-1:0] sweeps;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             up_down;
    logic             busy;
    logic             tc;
    logic             done;
    logic             err;

    modport master (
        output start, stop, hold, mode, lo, hi, sweeps,
        input  q, qb, up_down, busy, tc, done, err
    );

    modport slave (
        input  start, stop, hold, mode, lo, hi, sweeps,
        output q, qb, up_down, busy, tc, done, err
    );
endinterface

// File: rtl/updown_count_sequencer.sv
// Up/down count sequencer: runs the count register through single up/down sweeps,
// ping-pong sweeps with a reversal limit, or continuous up-wrap between latched bounds.
// The count never leaves [lo, hi], so no modular wrap through zero can occur.
module updown_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int SWP_W = 4
) (
    input logic                    clk,
    input logic                    rst,
    updown_count_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_UP   = 3'd1,
        RUN_DOWN = 3'd2,
        PAUSE    = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [SWP_W-1:0] SWP_ONE = SWP_W'(1);

    state_t           state;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [SWP_W-1:0] swp_r;
    logic [SWP_W-1:0] swp_cnt;
    logic [WIDTH-1:0] q_r;
    logic             up_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [SWP_W-1:0] swp_nxt;
    logic             swp_last;

    // Value after reversing at hi; clamps to lo when the range is a single value.
    function automatic logic [WIDTH-1:0] after_top(input logic [WIDTH-1:0] l,
                                                   input logic [WIDTH-1:0] h);
        return (h == l) ? l : h - ONE;
    endfunction

    // Value after reversing at lo; clamps to hi when the range is a single value.
    function automatic logic [WIDTH-1:0] after_bottom(input logic [WIDTH-1:0] l,
                                                      input logic [WIDTH-1:0] h);
        return (h == l) ? h : l + ONE;
    endfunction

    // A sweep limit of zero means the ping-pong / wrap sequence never finishes on its own.
    assign swp_nxt  = swp_cnt + SWP_ONE;
    assign swp_last = (swp_r != '0) && (swp_nxt == swp_r);

    assign bus.q       = q_r;
    assign bus.qb      = ~q_r;
    assign bus.up_down = up_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.tc      = ((state == RUN_UP)   && (q_r == hi_r)) ||
                         ((state == RUN_DOWN) && (q_r == lo_r));

    // Sequencer FSM, count register and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_r     <= '0;
            up_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            swp_cnt <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.lo > bus.hi) begin
                            err_r <= 1'b1;
                        end else begin
                            mode_r  <= bus.mode;
                            lo_r    <= bus.lo;
                            hi_r    <= bus.hi;
                            swp_r   <= bus.sweeps;
                            swp_cnt <= '0;
                            busy_r  <= 1'b1;
                            if (bus.mode == 2'b01) begin
                                q_r   <= bus.hi;
                                up_r  <= 1'b0;
                                state <= RUN_DOWN;
                            end else begin
                                q_r   <= bus.lo;
                                up_r  <= 1'b1;
                                state <= RUN_UP;
                            end
                        end
                    end
                end
                RUN_UP: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (bus.hold) begin
                        state <= PAUSE;
                    end else if (q_r != hi_r) begin
                        q_r <= q_r + ONE;
                    end else if (mode_r[1]) begin
                        swp_cnt <= swp_nxt;
                        if (swp_last) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else if (mode_r == 2'b10) begin
                            state <= RUN_DOWN;
                            up_r  <= 1'b0;
                            q_r   <= after_top(lo_r, hi_r);
                        end else begin
                            q_r <= lo_r;
                        end
                    end else begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                RUN_DOWN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (bus.hold) begin
                        state <= PAUSE;
                    end else if (q_r != lo_r) begin
                        q_r <= q_r - ONE;
                    end else if (mode_r == 2'b10) begin
                        swp_cnt <= swp_nxt;
                        if (swp_last) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            state <= RUN_UP;
                            up_r  <= 1'b1;
                            q_r   <= after_bottom(lo_r, hi_r);
                        end
                    end else begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (!bus.hold) begin
                        state <= up_r ? RUN_UP : RUN_DOWN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
